jk_updown_counter: RTL and testbench

- Modulo-N synchronous up/down counter whose state register is a bank of JK cells.
- The block contains the excitation logic that generates per-bit J/K inputs, plus the JK state bits themselves. Each bit updates as q' = (j & ~q) | (~k & q).
- It is the stage that drives JK flip-flop inputs. Counting, loading and holding are all expressed as J/K excitation vectors.
- Used as the event/sequence counter in the flip-flop lab designs.

---
 rtl/jk_updown_counter_if.sv | 25 ++
 rtl/jk_updown_counter.sv | 97 +++++++++
 tb/tb_jk_updown_counter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle of the JK up/down counter: the master drives controls,
// the counter (slave) returns its state, terminal count and J/K excitation.
interface jk_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrapped, j_vec, k_vec
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrapped, j_vec, k_vec
    );
endinterface

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state is a bank of JK cells; load, count
// and hold are all expressed as per-bit J/K excitation vectors.
module jk_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                clk,
    input  logic                rst,
    jk_updown_counter_if.slave  bus
);

    localparam longint unsigned SPAN = 64'(1) << WIDTH;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    generate
        if ((MODULUS < 2) || (64'(MODULUS) > SPAN)) begin : g_bad_modulus
            $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;

    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_illegal;
    logic             w_ld_over;
    logic             w_wrap;

    // Out-of-range detection only exists when the modulus leaves unused codes.
    generate
        if (64'(MODULUS) < SPAN) begin : g_partial
            assign w_illegal = (r_count > MAX);
            assign w_ld_over = (bus.load_val > MAX);
        end else begin : g_full
            assign w_illegal = 1'b0;
            assign w_ld_over = 1'b0;
        end
    endgenerate

    assign w_at_max  = (r_count == MAX);
    assign w_at_zero = (r_count == '0);
    assign w_wrap    = w_illegal | (bus.up ? w_at_max : w_at_zero);
    assign w_target  = w_ld_over ? MAX : bus.load_val;

    // Next count value for the enabled (non-load) case.
    always_comb begin
        w_next = r_count;
        if (w_illegal) begin
            w_next = '0;
        end else if (bus.up) begin
            w_next = w_at_max ? '0 : r_count + WIDTH'(1);
        end else begin
            w_next = w_at_zero ? MAX : r_count - WIDTH'(1);
        end
    end

    // Excitation: set/reset form for load, toggle form for count, zero for hold.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (bus.load) begin
            w_j = w_target & ~r_count;
            w_k = ~w_target & r_count;
        end else if (bus.en) begin
            w_j = r_count ^ w_next;
            w_k = r_count ^ w_next;
        end
    end

    // JK cell bank plus sticky wrap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_count <= (w_j & ~r_count) | (~w_k & r_count);
            if (bus.load) begin
                r_wrapped <= 1'b0;
            end else if (bus.en && w_wrap) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.wrapped = r_wrapped;
    assign bus.j_vec   = w_j;
    assign bus.k_vec   = w_k;
    assign bus.tc      = bus.en & ~bus.load &
                         ((bus.up & w_at_max) | (~bus.up & w_at_zero));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter: a MODULUS=10 instance and a full-range
// MODULUS=16 instance, with hand-computed expected values.
module tb_jk_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    jk_updown_counter_if #(.WIDTH(4)) bus10 ();
    jk_updown_counter_if #(.WIDTH(4)) bus16 ();

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10.slave)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive10(input logic en, input logic up, input logic load, input logic [3:0] lv);
        bus10.en = en; bus10.up = up; bus10.load = load; bus10.load_val = lv;
        #1;
    endtask

    task automatic test_reset();
        drive10(1'b0, 1'b1, 1'b0, 4'd0);
        bus16.en = 1'b0; bus16.up = 1'b1; bus16.load = 1'b0; bus16.load_val = 4'd0;
        rst = 1'b1;
        #3;
        n_total++; if (bus10.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus10.count); else n_pass++;
        n_total++; if (bus10.wrapped !== 1'b0) $display("FAIL reset_wrapped got=%0b exp=0", bus10.wrapped); else n_pass++;
        n_total++; if (bus10.tc !== 1'b0) $display("FAIL reset_tc got=%0b exp=0", bus10.tc); else n_pass++;
        n_total++; if (bus10.j_vec !== 4'd0 || bus10.k_vec !== 4'd0)
            $display("FAIL reset_jk got=%b/%b exp=0000/0000", bus10.j_vec, bus10.k_vec); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] cur;
        logic [3:0] nxt;
        drive10(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            cur = 4'(( i - 1) % 10);
            nxt = 4'(i % 10);
            n_total++; if (bus10.tc !== (cur == 4'd9))
                $display("FAIL up_tc[%0d] got=%0b exp=%0b", i, bus10.tc, cur == 4'd9); else n_pass++;
            n_total++; if (bus10.j_vec !== (cur ^ nxt) || bus10.k_vec !== (cur ^ nxt))
                $display("FAIL up_jk[%0d] got=%b/%b exp=%b", i, bus10.j_vec, bus10.k_vec, cur ^ nxt); else n_pass++;
            tick();
            n_total++; if (bus10.count !== nxt)
                $display("FAIL up_count[%0d] got=%0d exp=%0d", i, bus10.count, nxt); else n_pass++;
            n_total++; if (bus10.wrapped !== (i >= 10))
                $display("FAIL up_wrapped[%0d] got=%0b exp=%0b", i, bus10.wrapped, i >= 10); else n_pass++;
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_seq [4] = '{4'd9, 4'd8, 4'd7, 4'd6};
        rst = 1'b1;
        #1;
        n_total++; if (bus10.count !== 4'd0) $display("FAIL down_rst_count got=%0d exp=0", bus10.count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive10(1'b1, 1'b0, 1'b0, 4'd0);
        n_total++; if (bus10.tc !== 1'b1) $display("FAIL down_tc_at0 got=%0b exp=1", bus10.tc); else n_pass++;
        n_total++; if (bus10.j_vec !== 4'b1001) $display("FAIL down_j_at0 got=%b exp=1001", bus10.j_vec); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (bus10.count !== exp_seq[i])
                $display("FAIL down_count[%0d] got=%0d exp=%0d", i, bus10.count, exp_seq[i]); else n_pass++;
            n_total++; if (bus10.wrapped !== 1'b1)
                $display("FAIL down_wrapped[%0d] got=%0b exp=1", i, bus10.wrapped); else n_pass++;
            n_total++; if (bus10.tc !== 1'b0)
                $display("FAIL down_tc[%0d] got=%0b exp=0", i, bus10.tc); else n_pass++;
        end
        // Direction change: 6 -> 7 -> 6 -> 5 -> 4 -> 3 with no dead cycle.
        drive10(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        n_total++; if (bus10.count !== 4'd7) $display("FAIL dir_change_up got=%0d exp=7", bus10.count); else n_pass++;
        drive10(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        n_total++; if (bus10.count !== 4'd3) $display("FAIL dir_change_down got=%0d exp=3", bus10.count); else n_pass++;
    endtask

    task automatic test_load();
        drive10(1'b1, 1'b1, 1'b1, 4'd6);
        n_total++; if (bus10.j_vec !== 4'b0100 || bus10.k_vec !== 4'b0001)
            $display("FAIL load6_jk got=%b/%b exp=0100/0001", bus10.j_vec, bus10.k_vec); else n_pass++;
        n_total++; if (bus10.tc !== 1'b0) $display("FAIL load6_tc got=%0b exp=0", bus10.tc); else n_pass++;
        tick();
        n_total++; if (bus10.count !== 4'd6) $display("FAIL load6_count got=%0d exp=6", bus10.count); else n_pass++;
        n_total++; if (bus10.wrapped !== 1'b0) $display("FAIL load6_wrapped got=%0b exp=0", bus10.wrapped); else n_pass++;
        drive10(1'b0, 1'b0, 1'b1, 4'd13);
        n_total++; if (bus10.j_vec !== 4'b1001 || bus10.k_vec !== 4'b0110)
            $display("FAIL load13_jk got=%b/%b exp=1001/0110", bus10.j_vec, bus10.k_vec); else n_pass++;
        tick();
        n_total++; if (bus10.count !== 4'd9) $display("FAIL load13_clamp got=%0d exp=9", bus10.count); else n_pass++;
    endtask

    task automatic test_priority_hold();
        drive10(1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        n_total++; if (bus10.count !== 4'd2) $display("FAIL prio_count got=%0d exp=2", bus10.count); else n_pass++;
        drive10(1'b0, 1'b1, 1'b0, 4'd7);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (bus10.j_vec !== 4'd0 || bus10.k_vec !== 4'd0)
                $display("FAIL hold_jk[%0d] got=%b/%b exp=0000/0000", i, bus10.j_vec, bus10.k_vec); else n_pass++;
            tick();
            n_total++; if (bus10.count !== 4'd2 || bus10.wrapped !== 1'b0)
                $display("FAIL hold_state[%0d] got=%0d/%0b exp=2/0", i, bus10.count, bus10.wrapped); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        drive10(1'b0, 1'b1, 1'b1, 4'd8);
        tick();
        drive10(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) tick();
        n_total++; if (bus10.count !== 4'd7 || bus10.wrapped !== 1'b1)
            $display("FAIL pre_rst got=%0d/%0b exp=7/1", bus10.count, bus10.wrapped); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (bus10.count !== 4'd0 || bus10.wrapped !== 1'b0)
            $display("FAIL async_rst got=%0d/%0b exp=0/0", bus10.count, bus10.wrapped); else n_pass++;
        tick();
        n_total++; if (bus10.count !== 4'd0) $display("FAIL rst_held got=%0d exp=0", bus10.count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_total++; if (bus10.count !== 4'd1) $display("FAIL rst_release got=%0d exp=1", bus10.count); else n_pass++;
        // Load pending as reset releases takes effect on the first active edge.
        rst = 1'b1;
        drive10(1'b1, 1'b1, 1'b1, 4'd4);
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_total++; if (bus10.count !== 4'd4) $display("FAIL rst_load got=%0d exp=4", bus10.count); else n_pass++;
    endtask

    task automatic test_full_range();
        bus16.en = 1'b0; bus16.up = 1'b1; bus16.load = 1'b1; bus16.load_val = 4'd15;
        tick();
        n_total++; if (bus16.count !== 4'd15) $display("FAIL full_load got=%0d exp=15", bus16.count); else n_pass++;
        bus16.en = 1'b1; bus16.load = 1'b0;
        #1;
        n_total++; if (bus16.tc !== 1'b1) $display("FAIL full_up_tc got=%0b exp=1", bus16.tc); else n_pass++;
        n_total++; if (bus16.j_vec !== 4'b1111 || bus16.k_vec !== 4'b1111)
            $display("FAIL full_up_jk got=%b/%b exp=1111/1111", bus16.j_vec, bus16.k_vec); else n_pass++;
        tick();
        n_total++; if (bus16.count !== 4'd0 || bus16.wrapped !== 1'b1)
            $display("FAIL full_up_wrap got=%0d/%0b exp=0/1", bus16.count, bus16.wrapped); else n_pass++;
        bus16.up = 1'b0;
        #1;
        n_total++; if (bus16.tc !== 1'b1 || bus16.j_vec !== 4'b1111)
            $display("FAIL full_down_exc got=%0b/%b exp=1/1111", bus16.tc, bus16.j_vec); else n_pass++;
        tick();
        n_total++; if (bus16.count !== 4'd15) $display("FAIL full_down_wrap got=%0d exp=15", bus16.count); else n_pass++;
        bus16.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_priority_hold();
        test_async_reset();
        test_full_range();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
